// File: rtl/inverse_permutation_func_if.sv
`default_nettype none
// ============================================================================
//  Module      : inverse_permutation_func_if
//  Description : Memory-side bus of inverse_permutation_func: run control,
//                line read address/data and the write-back strobe.
//                Optional macro PI_FORWARD_SEL_EN adds the fwd select line.
//  Revision    : 1.0  initial release
// ============================================================================
interface inverse_permutation_func_if;
    logic        start;
    logic [24:0] line_in;
    logic [6:0]  cnt_value;
    logic        write_enable;
    logic [24:0] write_value;
    logic        donee;
`ifdef PI_FORWARD_SEL_EN
    logic        fwd;

    modport master (
        input  start,
        input  line_in,
        input  fwd,
        output cnt_value,
        output write_enable,
        output write_value,
        output donee
    );

    modport slave (
        output start,
        output line_in,
        output fwd,
        input  cnt_value,
        input  write_enable,
        input  write_value,
        input  donee
    );
`else
    modport master (
        input  start,
        input  line_in,
        output cnt_value,
        output write_enable,
        output write_value,
        output donee
    );

    modport slave (
        output start,
        output line_in,
        input  cnt_value,
        input  write_enable,
        input  write_value,
        input  donee
    );
`endif
endinterface
`default_nettype wire

// File: rtl/inverse_permutation_func.sv
`default_nettype none
// ============================================================================
//  Module      : inverse_permutation_func
//  Description : Streams LINES 25-bit Keccak slices from memory, applies the
//                inverse pi lane permutation and writes each result back via
//                a one-cycle strobe. Macro PI_FORWARD_SEL_EN adds a per-run
//                forward/inverse select (fwd).
//  Revision    : 1.0  initial release
// ============================================================================
module inverse_permutation_func #(
    parameter int LINES     = 64,
    parameter int ADDR_BASE = 63
) (
    input wire clk,
    input wire rst,
    inverse_permutation_func_if.master bus
);

    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [6:0]        c_addr_base = 7'(ADDR_BASE);
    localparam logic [LINE_W-1:0] c_last_line = LINE_W'(LINES - 1);
    localparam logic [LINE_W-1:0] c_line_one  = LINE_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [LINE_W-1:0] r_line;
    logic [24:0]       r_wval;
    logic              r_start_d;
    logic              r_start_seen;
    logic              w_start_edge;
    logic              w_we;
    logic              w_done;
    logic [24:0]       w_inv;
    logic [24:0]       w_slice;

    // Slice bit 5*y+x holds lane (x,y); inverse pi: out(x,y) = in(y,(2x+3y) mod 5).
    for (genvar gy = 0; gy < 5; gy++) begin : g_inv_y
        for (genvar gx = 0; gx < 5; gx++) begin : g_inv_x
            assign w_inv[5*gy+gx] = bus.line_in[5*((2*gx+3*gy)%5)+gy];
        end
    end

`ifdef PI_FORWARD_SEL_EN
    logic        r_fwd;
    logic [24:0] w_fwd;

    // Forward pi: out(x,y) = in((x+3y) mod 5, x).
    for (genvar gy = 0; gy < 5; gy++) begin : g_fwd_y
        for (genvar gx = 0; gx < 5; gx++) begin : g_fwd_x
            assign w_fwd[5*gy+gx] = bus.line_in[5*gx+((gx+3*gy)%5)];
        end
    end

    assign w_slice = r_fwd ? w_fwd : w_inv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd <= 1'b0;
        end else if ((r_state == c_st_idle) && w_start_edge) begin
            r_fwd <= bus.fwd;
        end
    end
`else
    assign w_slice = w_inv;
`endif

    // A start level already high when reset releases must not count as an
    // edge, so one post-reset sample is required before edges are accepted.
    assign w_start_edge = r_start_seen & ~r_start_d & bus.start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_start_edge) begin
                    w_state_nxt = c_st_read;
                end
            end
            c_st_read: begin
                w_state_nxt = c_st_write;
            end
            c_st_write: begin
                if (r_line == c_last_line) begin
                    w_state_nxt = c_st_done;
                end else begin
                    w_state_nxt = c_st_read;
                end
            end
            c_st_done: begin
                if (!bus.start) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_comb begin
        w_we   = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_st_write: w_we   = 1'b1;
            c_st_done:  w_done = 1'b1;
            default: begin
                w_we   = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line       <= '0;
            r_wval       <= '0;
            r_start_d    <= 1'b0;
            r_start_seen <= 1'b0;
        end else begin
            r_start_d    <= bus.start;
            r_start_seen <= 1'b1;
            case (r_state)
                c_st_idle: begin
                    r_line <= '0;
                end
                c_st_read: begin
                    r_wval <= w_slice;
                end
                c_st_write: begin
                    if (r_line != c_last_line) begin
                        r_line <= r_line + c_line_one;
                    end
                end
                c_st_done: begin
                    // Leaving DONE restores the idle output values.
                    if (!bus.start) begin
                        r_line <= '0;
                        r_wval <= '0;
                    end
                end
                default: begin
                    r_line <= '0;
                end
            endcase
        end
    end

    assign bus.cnt_value    = c_addr_base + 7'(r_line);
    assign bus.write_value  = r_wval;
    assign bus.write_enable = w_we;
    assign bus.donee        = w_done;

endmodule
`default_nettype wire
